// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider.
// Mode encodings and the default counter width.
package clk_div_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser, async active-high reset.
// Used to bring a level input into the inClk domain.
module sync_2ff (
  input  logic inClk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage shift, both stages clear on reset
  always_ff @(posedge inClk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable clock divider (toggle or pulse mode).
// Optional macro CLKDIV_EN_SYNC_EN adds a 2-flop synchroniser on en.
module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int   CNT_W        = DEF_CNT_W,
  parameter int   DEFAULT_HALF = 5,
  parameter logic DEFAULT_MODE = MODE_TOGGLE
) (
  input  logic             inClk,
  input  logic             reset,
  input  logic             en,
  input  logic             loadDiv,
  input  logic [CNT_W-1:0] halfPeriod,
  input  logic             modeIn,
  output logic             outClk,
  output logic             tick,
  output logic             loadPending,
  output logic [CNT_W-1:0] curHalf
);

  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

  logic             enEff;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] activeHalf;
  logic             activeMode;
  logic [CNT_W-1:0] shadowHalf;
  logic             shadowMode;
  logic [CNT_W-1:0] lastCnt;
  logic             boundary;
  logic             applyNow;

`ifdef CLKDIV_EN_SYNC_EN
  sync_2ff uEnSync (
    .inClk (inClk),
    .reset (reset),
    .d     (en),
    .q     (enEff)
  );
`else
  assign enEff = en;
`endif

  assign curHalf = activeHalf;

  // terminal count: a programmed 0 behaves like 1
  always_comb begin
    lastCnt  = '0;
    if (activeHalf != '0)
      lastCnt = activeHalf - 1'b1;
    boundary = enEff && (cnt == lastCnt);
    // a load landing on a boundary waits for the next one
    applyNow = boundary && loadPending && !loadDiv;
  end

  // counter, shadow/active settings and registered outputs
  always_ff @(posedge inClk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      outClk      <= 1'b0;
      tick        <= 1'b0;
      loadPending <= 1'b0;
      activeHalf  <= RST_HALF;
      activeMode  <= DEFAULT_MODE;
      shadowHalf  <= RST_HALF;
      shadowMode  <= DEFAULT_MODE;
    end else if (!enEff) begin
      tick <= 1'b0;
      if (loadDiv) begin
        activeHalf  <= halfPeriod;
        activeMode  <= modeIn;
        shadowHalf  <= halfPeriod;
        shadowMode  <= modeIn;
        cnt         <= '0;
        loadPending <= 1'b0;
      end
    end else begin
      if (loadDiv) begin
        shadowHalf  <= halfPeriod;
        shadowMode  <= modeIn;
        loadPending <= 1'b1;
      end
      if (boundary) begin
        cnt <= '0;
        if (activeMode == MODE_PULSE) begin
          outClk <= 1'b1;
          tick   <= 1'b1;
        end else begin
          outClk <= ~outClk;
          tick   <= ~outClk;
        end
        if (applyNow) begin
          activeHalf  <= shadowHalf;
          activeMode  <= shadowMode;
          loadPending <= 1'b0;
        end
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
        if (activeMode == MODE_PULSE)
          outClk <= 1'b0;
      end
    end
  end

endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
- Runtime-programmable successor to the fixed divide-by-10 clock divider.
- Divides `inClk` by a loadable half-period and runs in one of two modes: square-wave toggle or single-cycle pulse.
- Divisor/mode updates are glitch-free: the new setting is applied only at a period boundary.
- Feeds slow-tick consumers (debouncers, display scanners, lab timers) from the board clock.

Parameters:
- CNT_W, 16, width of the half-period counter and of `halfPeriod`.
- DEFAULT_HALF, 5, half-period (in `inClk` cycles) loaded at reset; 5 gives `inClk`/10 in toggle mode.
- DEFAULT_MODE, 0, mode loaded at reset (0 = toggle, 1 = pulse).

Ports:
- inClk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  count enable; 0 freezes the counter and outputs.
- loadDiv  in  1  single-cycle strobe; captures `halfPeriod` and `modeIn` into the shadow register.
- halfPeriod  in  CNT_W  requested half-period (cycles); 0 is treated as 1.
- modeIn  in  1  requested mode (0 toggle, 1 pulse).
- outClk  out  1  divided clock (toggle) or pulse train (pulse); registered.
- tick  out  1  one-cycle strobe, high in the same cycle `outClk` rises.
- loadPending  out  1  shadow holds a value not yet applied.
- curHalf  out  CNT_W  active half-period currently in use.

Behaviour:
- **Clock and reset.** Single clock, `inClk`; reset is asynchronous and active-high.
- **Reset values.** `cnt`=0, `outClk`=0, `tick`=0, `loadPending`=0, active and shadow half-period = DEFAULT_HALF, active mode = DEFAULT_MODE.
- **Effective half-period.** H_eff = max(active half-period, 1).
- **Counting (en=1).**
  - If `cnt` == H_eff-1: `cnt`<=0 and a boundary occurs.
  - Otherwise `cnt`<=`cnt`+1 and `tick`<=0.
- **Toggle mode, at a boundary.** `outClk`<=~`outClk`; `tick`<=1 iff old `outClk`==0. Output period is 2*H_eff cycles with 50% duty.
- **Pulse mode.**
  - At a boundary: `outClk`<=1, `tick`<=1.
  - Non-boundary cycles: `outClk`<=0.
  - Result: one-cycle-high pulse every H_eff cycles. With H_eff=1, `outClk` and `tick` are constantly 1.
- **Enable low (en=0).** `cnt`, `outClk` and `mode` hold; `tick`<=0.
- **Load while en=1.**
  - `loadDiv` writes the shadow register and sets `loadPending`=1.
  - At the next boundary strictly after the load cycle, shadow is copied to active and `loadPending`<=0.
  - The boundary cycle's output follows the old mode; the new half-period and mode govern from the following cycle.
  - Switching toggle->pulse from `outClk`=1: `outClk` drops to 0 on the next non-boundary cycle.
- **Load coincident with a boundary.** Not applied at that boundary; applied at the next one.
- **Repeated loads while pending.** The last written value wins; only one apply occurs.
- **Load while en=0.** Applied immediately the next cycle: active<=new, `cnt`<=0, `loadPending` stays 0, `outClk` holds.
- **Reset mid-period or mid-pending.** Reset overrides everything; the pending load is discarded.
- **Counter width.** `cnt` is CNT_W bits and never exceeds H_eff-1, so it cannot wrap.
- **Status outputs.** `curHalf` shows the active value, not H_eff (0 reads back as 0).

Optional Feature:
- **Macro:** CLKDIV_EN_SYNC_EN.
- **Defined:**
  - `en` passes through a 2-flop synchroniser before use, so enable/disable takes effect 2 cycles later.
  - The "load while en=0" path uses the synchronised `en`.
  - Synchroniser flops reset to 0.
- **Undefined:** `en` is used directly (same-cycle effect); no extra flops.

Decomposition:
- **Package `clk_div_pkg`:** MODE_TOGGLE=1'b0, MODE_PULSE=1'b1, default CNT_W.
- **Sub-module `sync_2ff`:** 1-bit 2-flop synchroniser with async active-high reset, instantiated only under CLKDIV_EN_SYNC_EN.
- **Top level:** counter, shadow register and output logic stay in `clk_divider_prog`.

Test Plan:
1. **Reset defaults, toggle.** Reset, en=1, DEFAULT_HALF=5, toggle -> `outClk` period 10 cycles, 5 high/5 low; `tick` one cycle per rising edge; `curHalf`=5.
2. **Load mid-period.** At `cnt`=2, load `halfPeriod`=3 -> `loadPending`=1 until the next boundary; following half-periods are 3 cycles; `curHalf`=3 after apply.
3. **Pulse mode, H=4.** Load `modeIn`=1, `halfPeriod`=4 -> after apply, `outClk`=`tick`=1 for one cycle every 4 cycles; `halfPeriod`=0 gives `outClk` constantly 1.
4. **Enable hold and idle load.** en=0 for 7 cycles mid-period -> `cnt`/`outClk` frozen, `tick`=0. Load 2 while en=0 -> applied next cycle, `cnt`=0, `loadPending` stays 0.
5. **Load edge cases.**
   - Load 6 in the boundary cycle -> not applied at that boundary, applied at the next.
   - Back-to-back loads 7 then 9 -> only 9 is applied.
6. **Reset during pending load.** Async reset asserted while pending -> all outputs return to reset values immediately and the pending value is lost. With CLKDIV_EN_SYNC_EN, an en rise shows 2 extra cycles of latency.
